// File: rtl/axi_stream_fifo_if.sv
// -----------------------------------------------------------------------------
// axi_stream_fifo_if
// AXI-Stream beat bundle shared by both sides of axi_stream_fifo.
//   tvalid/tready : handshake
//   tdata/tkeep   : payload and byte enables
//   tlast         : end of packet
//   tid/tdest/tuser : optional sidebands
// The master modport drives the beat; the slave modport drives tready.
// -----------------------------------------------------------------------------
interface axi_stream_fifo_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int TID_WIDTH   = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1
);
   logic                      tvalid;
   logic                      tready;
   logic [DATA_WIDTH-1:0]     tdata;
   logic [DATA_WIDTH/8-1:0]   tkeep;
   logic                      tlast;
   logic [TID_WIDTH-1:0]      tid;
   logic [TDEST_WIDTH-1:0]    tdest;
   logic [TUSER_WIDTH-1:0]    tuser;

   modport master (
      output tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
      output tready
   );
endinterface

// File: rtl/axi_stream_fifo.sv
// -----------------------------------------------------------------------------
// axi_stream_fifo
// First-word-fall-through AXI-Stream FIFO sitting behind the width upsizer.
// Buffers wide beats so downstream back-pressure does not stall the upsizer.
// Ports:
//   aclk, areset_n : clock, asynchronous active-low reset
//   s_axis         : input stream (slave modport)
//   m_axis         : output stream (master modport), payload zero while idle
//   occupancy      : stored beats, 0..DEPTH
//   pkt_count      : stored beats carrying tlast
//   almost_full    : occupancy >= ALMOST_FULL_LEVEL
// -----------------------------------------------------------------------------
module axi_stream_fifo #(
   parameter int DATA_WIDTH        = 64,
   parameter int DEPTH             = 16,
   parameter int TID_WIDTH         = 1,
   parameter int TDEST_WIDTH       = 1,
   parameter int TUSER_WIDTH       = 1,
   parameter int TID_EN            = 0,
   parameter int TDEST_EN          = 0,
   parameter int TUSER_EN          = 0,
   parameter int ALMOST_FULL_LEVEL = 12
) (
   input  logic                        aclk,
   input  logic                        areset_n,
   axi_stream_fifo_if.slave            s_axis,
   axi_stream_fifo_if.master           m_axis,
   output logic [$clog2(DEPTH):0]      occupancy,
   output logic [$clog2(DEPTH):0]      pkt_count,
   output logic                        almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int KW = DATA_WIDTH / 8;
   localparam int EW = DATA_WIDTH + KW + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

   logic [EW-1:0]          r_mem [DEPTH];
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [PW-1:0]          r_pkt_count;
   logic                   r_run;

   logic [PW-1:0]          w_occupancy;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_s_ready;
   logic                   w_push;
   logic                   w_pop;
   logic [TID_WIDTH-1:0]   w_tid;
   logic [TDEST_WIDTH-1:0] w_tdest;
   logic [TUSER_WIDTH-1:0] w_tuser;
   logic [EW-1:0]          w_wr_entry;
   logic [EW-1:0]          w_rd_entry;
   logic [PW-1:0]          w_pkt_next;

   logic [DATA_WIDTH-1:0]  w_m_tdata;
   logic [KW-1:0]          w_m_tkeep;
   logic                   w_m_tlast;
   logic [TID_WIDTH-1:0]   w_m_tid;
   logic [TDEST_WIDTH-1:0] w_m_tdest;
   logic [TUSER_WIDTH-1:0] w_m_tuser;

   // Pointers carry one extra bit, so their difference is the exact occupancy,
   // including the full case where the low bits match and the MSBs differ.
   assign w_occupancy = r_wr_ptr - r_rd_ptr;
   assign w_full      = (w_occupancy == PW'(DEPTH));
   assign w_empty     = (w_occupancy == {PW{1'b0}});

   // r_run holds tready low for the first edge after reset release.
   // Ready depends on stored state only: a pop while full never makes room
   // for a push in the same cycle.
   assign w_s_ready = r_run & ~w_full;
   assign w_push    = s_axis.tvalid & w_s_ready;
   assign w_pop     = ~w_empty & m_axis.tready;

   // Disabled sidebands are stored as zero so the output reads constant 0.
   always_comb begin
      w_tid   = {TID_WIDTH{1'b0}};
      w_tdest = {TDEST_WIDTH{1'b0}};
      w_tuser = {TUSER_WIDTH{1'b0}};
      if (TID_EN != 0) begin
         w_tid = s_axis.tid;
      end else begin
         w_tid = {TID_WIDTH{1'b0}};
      end
      if (TDEST_EN != 0) begin
         w_tdest = s_axis.tdest;
      end else begin
         w_tdest = {TDEST_WIDTH{1'b0}};
      end
      if (TUSER_EN != 0) begin
         w_tuser = s_axis.tuser;
      end else begin
         w_tuser = {TUSER_WIDTH{1'b0}};
      end
   end

   assign w_wr_entry = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, w_tid, w_tdest, w_tuser};
   assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

   // Storage array: written on push, intentionally never reset.
   always_ff @(posedge aclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
      end
   end

   // Run flag: released one clock after reset deasserts.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // Write and read pointers.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // Packet counter next value: net of tlast pushed and tlast popped.
   always_comb begin
      w_pkt_next = r_pkt_count;
      case ({w_push & s_axis.tlast, w_pop & w_m_tlast})
         2'b10:   w_pkt_next = r_pkt_count + PW'(1);
         2'b01:   w_pkt_next = r_pkt_count - PW'(1);
         default: w_pkt_next = r_pkt_count;
      endcase
   end

   // Packet counter register.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_pkt_count <= {PW{1'b0}};
      end else begin
         r_pkt_count <= w_pkt_next;
      end
   end

   // Head-of-queue unpack; all payload forced to zero while nothing is valid.
   always_comb begin
      w_m_tdata = {DATA_WIDTH{1'b0}};
      w_m_tkeep = {KW{1'b0}};
      w_m_tlast = 1'b0;
      w_m_tid   = {TID_WIDTH{1'b0}};
      w_m_tdest = {TDEST_WIDTH{1'b0}};
      w_m_tuser = {TUSER_WIDTH{1'b0}};
      if (!w_empty) begin
         {w_m_tdata, w_m_tkeep, w_m_tlast, w_m_tid, w_m_tdest, w_m_tuser} = w_rd_entry;
      end else begin
         w_m_tdata = {DATA_WIDTH{1'b0}};
      end
   end

   assign s_axis.tready = w_s_ready;
   assign m_axis.tvalid = ~w_empty;
   assign m_axis.tdata  = w_m_tdata;
   assign m_axis.tkeep  = w_m_tkeep;
   assign m_axis.tlast  = w_m_tlast;
   assign m_axis.tid    = w_m_tid;
   assign m_axis.tdest  = w_m_tdest;
   assign m_axis.tuser  = w_m_tuser;

   assign occupancy   = w_occupancy;
   assign pkt_count   = r_pkt_count;
   assign almost_full = (w_occupancy >= PW'(ALMOST_FULL_LEVEL));

endmodule

// File: tb/tb_axi_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_fifo
// Directed and randomised stimulus with a queue-based reference model.
// The DUT is built with TID_EN=1, TDEST_EN=0, TUSER_EN=0.
// -----------------------------------------------------------------------------
module tb_axi_stream_fifo;

   localparam int DW    = 64;
   localparam int DEPTH = 16;
   localparam int AFL   = 12;

   logic       aclk;
   logic       areset_n;
   logic [4:0] occ;
   logic [4:0] pkt;
   logic       af;

   axi_stream_fifo_if #(.DATA_WIDTH(DW)) s_if ();
   axi_stream_fifo_if #(.DATA_WIDTH(DW)) m_if ();

   axi_stream_fifo #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1),
      .TID_EN(1), .TDEST_EN(0), .TUSER_EN(0), .ALMOST_FULL_LEVEL(AFL)
   ) dut (
      .aclk        (aclk),
      .areset_n    (areset_n),
      .s_axis      (s_if),
      .m_axis      (m_if),
      .occupancy   (occ),
      .pkt_count   (pkt),
      .almost_full (af)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        id;
   } beat_t;

   beat_t q[$];
   bit    rst_done;
   int    n_vec;
   int    n_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the model state.
   task automatic check_all();
      bit          ev;
      int          np;
      logic [63:0] ed;
      logic [7:0]  ek;
      logic        el;
      logic        eid;
      ev  = (q.size() != 0);
      np  = 0;
      foreach (q[i]) if (q[i].l) np++;
      ed  = ev ? q[0].d  : 64'd0;
      ek  = ev ? q[0].k  : 8'd0;
      el  = ev ? q[0].l  : 1'b0;
      eid = ev ? q[0].id : 1'b0;
      chk("m_tvalid", {63'd0, m_if.tvalid}, {63'd0, ev});
      chk("s_tready", {63'd0, s_if.tready}, {63'd0, (rst_done && q.size() < DEPTH)});
      chk("m_tdata",  m_if.tdata, ed);
      chk("m_tkeep",  {56'd0, m_if.tkeep}, {56'd0, ek});
      chk("m_tlast",  {63'd0, m_if.tlast}, {63'd0, el});
      chk("m_tid",    {63'd0, m_if.tid},   {63'd0, eid});
      chk("m_tdest",  {63'd0, m_if.tdest}, 64'd0);
      chk("m_tuser",  {63'd0, m_if.tuser}, 64'd0);
      chk("occupancy", {59'd0, occ}, 64'(q.size()));
      chk("pkt_count", {59'd0, pkt}, 64'(np));
      chk("almost_full", {63'd0, af}, {63'd0, (q.size() >= AFL)});
   endtask

   // One clock: drive at the falling edge, update the model at the rising
   // edge, check at the next falling edge.
   task automatic cycle(input logic sv, input logic [63:0] d, input logic [7:0] k,
                        input logic l, input logic id, input logic dest,
                        input logic mr, output bit pushed);
      bit    push;
      bit    pop;
      beat_t b;
      s_if.tvalid = sv;
      s_if.tdata  = d;
      s_if.tkeep  = k;
      s_if.tlast  = l;
      s_if.tid    = id;
      s_if.tdest  = dest;
      s_if.tuser  = 1'b1;
      m_if.tready = mr;
      push = sv && rst_done && (q.size() < DEPTH);
      pop  = mr && (q.size() != 0);
      b.d = d; b.k = k; b.l = l; b.id = id;
      @(posedge aclk);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(b);
      rst_done = areset_n;
      pushed = push;
      @(negedge aclk);
      check_all();
   endtask

   initial begin
      bit          p;
      int          left;
      int          pushed_n;
      logic [63:0] d;
      n_vec = 0;
      n_err = 0;
      rst_done = 1'b0;
      areset_n = 1'b0;
      s_if.tvalid = 1'b0; s_if.tdata = 64'd0; s_if.tkeep = 8'd0; s_if.tlast = 1'b0;
      s_if.tid = 1'b0; s_if.tdest = 1'b0; s_if.tuser = 1'b0;
      m_if.tready = 1'b0;

      // Reset held: everything idle, tready low.
      repeat (2) @(negedge aclk);
      check_all();
      areset_n = 1'b1;
      cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, p);
      cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, p);

      // Single beat, held 5 cycles under back-pressure.
      cycle(1'b1, 64'h0011223344556677, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, p);
      repeat (5) cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, p);
      cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, p);

      // Fill to full, offer a 17th beat, then drain.
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 64'h1000 + 64'(i), 8'hF0, (i % 4 == 3), i[0], 1'b0, 1'b0, p);
      cycle(1'b1, 64'hDEAD, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, p);
      chk("17th_rejected", {63'd0, p}, 64'd0);
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, p);

      // Full with pop and valid input on the same cycle: no pass-through.
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 64'h2000 + 64'(i), 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, p);
      cycle(1'b1, 64'hBEEF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, p);
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, p);

      // Continuous streaming: occupancy settles at 1.
      for (int i = 0; i < 100; i++)
         cycle(1'b1, 64'h5000 + 64'(i), 8'hFF, (i % 5 == 4), 1'b0, 1'b0, 1'b1, p);
      cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, p);

      // Random valid/ready, packets of 1..7 beats.
      left = 0;
      pushed_n = 0;
      for (int c = 0; c < 20000 && pushed_n < 1000; c++) begin
         if (left == 0) left = $urandom_range(1, 7);
         d = {$urandom, $urandom};
         cycle(1'($urandom_range(0, 1)), d, 8'($urandom), (left == 1), 1'($urandom),
               1'($urandom), 1'($urandom_range(0, 1)), p);
         if (p) begin
            left--;
            pushed_n++;
         end
      end
      chk("random_beats", 64'(pushed_n), 64'd1000);
      for (int c = 0; c < 40 && q.size() != 0; c++)
         cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, p);
      chk("random_drained", 64'(q.size()), 64'd0);

      // Sidebands: tid forwarded, tdest/tuser forced to 0.
      cycle(1'b1, 64'h77, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, p);
      cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, p);

      // Reset at occupancy 9: outputs clear asynchronously.
      for (int i = 0; i < 9; i++)
         cycle(1'b1, 64'h9000 + 64'(i), 8'hFF, (i == 4), 1'b1, 1'b0, 1'b0, p);
      #2 areset_n = 1'b0;
      #1;
      chk("async_tvalid", {63'd0, m_if.tvalid}, 64'd0);
      chk("async_occ",    {59'd0, occ}, 64'd0);
      chk("async_pkt",    {59'd0, pkt}, 64'd0);
      chk("async_tready", {63'd0, s_if.tready}, 64'd0);
      chk("async_tdata",  m_if.tdata, 64'd0);
      q.delete();
      rst_done = 1'b0;
      @(negedge aclk);
      check_all();
      areset_n = 1'b1;
      cycle(1'b1, 64'hBAD0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, p);
      chk("release_no_push", {63'd0, p}, 64'd0);
      cycle(1'b1, 64'hF1257, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, p);
      chk("post_rst_first", m_if.tdata, 64'hF1257);
      cycle(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, p);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
